icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Miss-handling sequencer for the pc-tagged fully-associative instruction cache.
- Accepts one miss at a time from fetch and issues a burst read to the memory bus starting at the missed pc.
- Streams returned words into the cache single write port as (pc, inst) pairs.
- Returns the missed instruction to fetch. A flush input cancels or drains an in-flight refill.

Parameters:
- BURST_LEN, 4, words fetched per miss (1..16); sequential pcs miss_pc, miss_pc+4, ...
- PC_W, 32, pc / address width
- INST_W, 32, instruction width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- flush_i  in  1  pipeline flush; cancels the current refill
- miss_valid_i  in  1  fetch reports a miss
- miss_pc_i  in  PC_W  missed pc
- miss_ready_o  out  1  miss accepted this cycle
- refill_done_o  out  1  one-cycle pulse; missed instruction available
- refill_inst_o  out  INST_W  instruction at miss_pc, valid with refill_done_o
- mem_req_o  out  1  burst read request
- mem_addr_o  out  PC_W  burst start address
- mem_len_o  out  4  BURST_LEN-1
- mem_ack_i  in  1  request accepted
- mem_rvalid_i  in  1  data beat valid
- mem_rdata_i  in  INST_W  data beat
- cache_we_o  out  1  cache write enable
- cache_wpc_o  out  PC_W  tag (pc) written
- cache_winst_o  out  INST_W  data written

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0; base pc 0.
- FSM states: IDLE, REQ, RECV, DRAIN.
- IDLE:
  - miss_ready_o = 1 (combinational, IDLE only).
  - On miss_valid_i & !flush_i: latch miss_pc_i into base, go to REQ.
- REQ:
  - mem_req_o = 1, mem_addr_o = base, mem_len_o = BURST_LEN-1, all held stable until mem_ack_i.
  - mem_ack_i & !flush_i: counter <= 0, go to RECV.
  - flush_i without ack: go to IDLE; nothing written.
  - flush_i with ack in the same cycle: go to DRAIN, because the burst is committed.
- RECV:
  - Each mem_rvalid_i beat k (0..BURST_LEN-1) produces, one cycle later: cache_we_o = 1, cache_wpc_o = base + 4*k, cache_winst_o = beat data.
  - Address arithmetic is modulo 2^PC_W; wrap past 0xFFFF_FFFC is permitted.
  - Beat 0 additionally pulses refill_done_o with refill_inst_o = data, in the same cycle as its cache write.
  - After the last beat (k = BURST_LEN-1), go to IDLE. miss_ready_o rises the cycle after the final beat is accepted.
- DRAIN:
  - Entered on flush_i in RECV, including a flush in the same cycle as a beat; that beat is also discarded.
  - Remaining beats are consumed and counted, with no cache_we_o and no refill_done_o.
  - After the last beat, go to IDLE.
  - flush_i while already in DRAIN or IDLE has no effect.
- Gaps between beats (mem_rvalid_i low) are legal and do not change state.
- mem_rvalid_i outside RECV/DRAIN is ignored.
- cache_we_o and refill_done_o are single-cycle pulses; the data outputs hold their last value when not pulsed.
- Synchronous reset mid-burst returns to IDLE immediately.
  - The memory side must be reset in the same cycle; no drain is performed.
- Only one outstanding burst exists at any time.

Optional Feature:
- Macro: ICACHE_REFILL_PERF_EN.
- Defined:
  - Adds output ports miss_cnt_o[31:0] and flush_cnt_o[31:0].
  - miss_cnt_o increments on each accepted miss (IDLE handshake).
  - flush_cnt_o increments on each REQ->IDLE or ->DRAIN cancel.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header, alongside the existing bus-width defines:
  - state encoding localparams (IDLE=2'd0, REQ=2'd1, RECV=2'd2, DRAIN=2'd3);
  - a packed ICacheWriteIbus width macro {we, pc, inst}, so that cache_* feeds the cache write bus directly;
  - a mem-read request bus width macro.
- Sub-module: icache_refill_beat_cnt, which holds the beat counter, the last-beat detect and the pc offset adder.
- FSM and output registers stay in the top module.

Test Plan:
- Basic miss:
  - Stimulus: miss_pc 0x1C00_0000, ack after 2 cycles, 4 back-to-back beats 0xA0..0xA3.
  - Required: cache writes (0x1C00_0000,0xA0) through (0x1C00_000C,0xA3) on consecutive cycles; refill_done with 0xA0 coinciding with the first write; miss_ready high the cycle after the last beat.
- Gapped beats:
  - Stimulus: beats spaced 1, 3 and 0 idle cycles apart.
  - Required: exactly 4 writes with correct pcs; no extra we pulses.
- Flush in REQ before ack:
  - Required: mem_req drops the next cycle, FSM returns to IDLE, zero cache writes.
  - A subsequent miss at 0x0000_0040 completes normally.
- Flush in RECV after beat 1:
  - Required: writes for beats 0 and 1 only; beats 2 and 3 consumed silently; the next miss is accepted only after beat 3.
- Wrap:
  - Stimulus: miss_pc 0xFFFF_FFF8.
  - Required: write pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Reset mid-RECV:
  - Required: all outputs 0 the next cycle, state IDLE, miss_ready 1.
  - With ICACHE_REFILL_PERF_EN: counters read 0 after reset and 1 after the next accepted miss.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill sequencer:
// state encoding, bus width macros and the saturating counter helper.
`ifndef ICACHE_REFILL_CTRL_DEFS
`define ICACHE_REFILL_CTRL_DEFS
// Cache write bus packed as {we, pc, inst}
`define ICACHE_WRITE_IBUS_W(pw, iw) (1 + (pw) + (iw))
// Memory read request bus packed as {req, addr, len[3:0]}
`define MEM_RD_REQ_W(pw) (1 + (pw) + 4)
`endif

package icache_refill_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RECV  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        RECV  = ST_RECV,
        DRAIN = ST_DRAIN
    } refill_state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_refill_beat_cnt.sv
// Beat counter for a refill burst: counts accepted beats, flags the
// first and last beat and forms the pc of the current beat.
module icache_refill_beat_cnt #(
    parameter int BURST_LEN = 4,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic [PC_W-1:0] base,
    output logic            first,
    output logic            last,
    output logic [PC_W-1:0] beat_pc
);

    localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

    logic [3:0] cnt_q;

    // Beat index: cleared when a burst is committed, bumped per beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd0;
        end else if (inc) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign first   = (cnt_q == 4'd0);
    assign last    = (cnt_q == LAST_IDX);
    // Wraps modulo 2^PC_W by construction
    assign beat_pc = base + PC_W'({cnt_q, 2'b00});

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill sequencer: one burst per miss, streams
// beats into the cache. Optional perf counters: ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int PC_W      = 32,
    parameter int INST_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              miss_valid_i,
    input  logic [PC_W-1:0]   miss_pc_i,
    output logic              miss_ready_o,
    output logic              refill_done_o,
    output logic [INST_W-1:0] refill_inst_o,
    output logic              mem_req_o,
    output logic [PC_W-1:0]   mem_addr_o,
    output logic [3:0]        mem_len_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic              cache_we_o,
    output logic [PC_W-1:0]   cache_wpc_o,
    output logic [INST_W-1:0] cache_winst_o
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int WBUS_W = `ICACHE_WRITE_IBUS_W(PC_W, INST_W);
    localparam int RBUS_W = `MEM_RD_REQ_W(PC_W);
    localparam logic [3:0] LEN = 4'(BURST_LEN - 1);

    refill_state_e     state_q;
    logic [WBUS_W-1:0] wbus_q;
    logic [RBUS_W-1:0] rbus_q;
    logic              done_q;
    logic [INST_W-1:0] done_inst_q;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              beat_first;
    logic              beat_last;
    logic [PC_W-1:0]   base;
    logic [PC_W-1:0]   beat_pc;

    // The request bus address field doubles as the burst base pc
    assign base    = rbus_q[4 +: PC_W];
    assign cnt_clr = (state_q == REQ) && mem_ack_i;
    assign cnt_inc = ((state_q == RECV) || (state_q == DRAIN))
                   && mem_rvalid_i;

    icache_refill_beat_cnt #(
        .BURST_LEN (BURST_LEN),
        .PC_W      (PC_W)
    ) u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .base    (base),
        .first   (beat_first),
        .last    (beat_last),
        .beat_pc (beat_pc)
    );

    // Refill FSM with registered memory, cache and fetch outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wbus_q      <= '0;
            rbus_q      <= '0;
            done_q      <= 1'b0;
            done_inst_q <= '0;
        end else begin
            wbus_q[WBUS_W-1] <= 1'b0;
            done_q           <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_valid_i && !flush_i) begin
                        rbus_q  <= {1'b1, miss_pc_i, LEN};
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        // An acked burst is committed and must drain
                        rbus_q[RBUS_W-1] <= 1'b0;
                        state_q <= mem_ack_i ? DRAIN : IDLE;
                    end else if (mem_ack_i) begin
                        rbus_q[RBUS_W-1] <= 1'b0;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (flush_i) begin
                        if (mem_rvalid_i && beat_last) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (mem_rvalid_i) begin
                        wbus_q <= {1'b1, beat_pc, mem_rdata_i};
                        if (beat_first) begin
                            done_q      <= 1'b1;
                            done_inst_q <= mem_rdata_i;
                        end
                        if (beat_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rvalid_i && beat_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miss_ready_o  = (state_q == IDLE);
    assign refill_done_o = done_q;
    assign refill_inst_o = done_inst_q;
    assign {mem_req_o, mem_addr_o, mem_len_o} = rbus_q;
    assign {cache_we_o, cache_wpc_o, cache_winst_o} = wbus_q;

`ifdef ICACHE_REFILL_PERF_EN
    logic        miss_acc;
    logic        cancel;
    logic [31:0] miss_cnt_q;
    logic [31:0] flush_cnt_q;

    assign miss_acc = (state_q == IDLE) && miss_valid_i && !flush_i;
    assign cancel   = flush_i
                    && ((state_q == REQ) || (state_q == RECV));

    // Saturating counts of accepted misses and cancelled refills
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_cnt_q  <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (miss_acc) begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
            end
            if (cancel) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign miss_cnt_o  = miss_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
